// File: rtl/pid_channel_scheduler_if.sv
// Bus between the channel scheduler and the shared PID core: channel operands and strobe out, result back.
interface pid_channel_scheduler_if #(
  parameter int unsigned CH_W = 2
);
  logic [CH_W-1:0] pid_ch;
  logic [15:0]     pid_speed_set;
  logic [15:0]     pid_curr_speed;
  logic            ctrl_en;
  logic [15:0]     pid_result;

  modport master (
    output pid_ch, pid_speed_set, pid_curr_speed, ctrl_en,
    input  pid_result
  );

  modport slave (
    input  pid_ch, pid_speed_set, pid_curr_speed, ctrl_en,
    output pid_result
  );
endinterface

// File: rtl/pid_channel_scheduler.sv
// Time-multiplexes one shared PID core over NUM_CH motor channels, one round per control-period tick.
// Each enabled channel takes LOAD, FIRE, PID_LAT WAIT cycles and CAPTURE; masked channels are skipped.
module pid_channel_scheduler #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned PERIOD_CYCLES = 100000,
  parameter int unsigned PID_LAT       = 8
) (
  input  logic                     iClk100M,
  input  logic                     iRst,
  input  logic                     iEnable,
  input  logic [NUM_CH-1:0]        iChMask,
  input  logic [16*NUM_CH-1:0]     iSpeedSet,
  input  logic [16*NUM_CH-1:0]     iCurrSpeed,
  input  logic                     iClrOverrun,
  pid_channel_scheduler_if.master  pid_if,
  output logic [16*NUM_CH-1:0]     oSpeedPID,
  output logic [NUM_CH-1:0]        oValid,
  output logic                     oBusy,
  output logic                     oRoundDone,
  output logic                     oOverrun
);

  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned WAIT_W = $clog2(PID_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_CAPTURE
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [CH_W-1:0]       ch_q;
  logic [NUM_CH-1:0]     mask_q;
  logic [16*NUM_CH-1:0]  set_snap_q;
  logic [16*NUM_CH-1:0]  cur_snap_q;
  logic [15:0]           pid_set_q;
  logic [15:0]           pid_cur_q;
  logic                  ctrl_en_q;
  logic [16*NUM_CH-1:0]  spid_q;
  logic [NUM_CH-1:0]     valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovr_q;

  logic                  tick;
  logic [CH_W:0]         first_w;
  logic [CH_W:0]         next_w;
  logic [CH_W-1:0]       first_ch;
  logic [CH_W-1:0]       next_ch;

  // Lowest set bit of m at index >= lo, returned as {found, index}.
  function automatic logic [CH_W:0] find_next(input logic [NUM_CH-1:0] m, input int lo);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  assign tick     = iEnable && (cnt_q == CNT_W'(PERIOD_CYCLES - 1));
  assign first_w  = find_next(iChMask, 0);
  assign next_w   = find_next(mask_q, int'(ch_q) + 1);
  assign first_ch = first_w[CH_W-1:0];
  assign next_ch  = next_w[CH_W-1:0];

  always_ff @(posedge iClk100M) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      ch_q       <= '0;
      mask_q     <= '0;
      set_snap_q <= '0;
      cur_snap_q <= '0;
      pid_set_q  <= '0;
      pid_cur_q  <= '0;
      ctrl_en_q  <= 1'b0;
      spid_q     <= '0;
      valid_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      valid_q   <= '0;
      done_q    <= 1'b0;
      ctrl_en_q <= 1'b0;

      if (!iEnable || tick) cnt_q <= '0;
      else                  cnt_q <= cnt_q + CNT_W'(1);

      // A tick that finds a round still running is dropped and flagged.
      if (iClrOverrun)                   ovr_q <= 1'b0;
      else if (tick && state_q != S_IDLE) ovr_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (tick && (|iChMask)) begin
            mask_q     <= iChMask;
            set_snap_q <= iSpeedSet;
            cur_snap_q <= iCurrSpeed;
            ch_q       <= first_ch;
            pid_set_q  <= iSpeedSet[{first_ch, 4'b0000} +: 16];
            pid_cur_q  <= iCurrSpeed[{first_ch, 4'b0000} +: 16];
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          ctrl_en_q <= 1'b1;
          state_q   <= S_FIRE;
        end
        S_FIRE: begin
          wait_q  <= WAIT_W'(PID_LAT - 1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_q == '0) state_q <= S_CAPTURE;
          else              wait_q  <= wait_q - WAIT_W'(1);
        end
        S_CAPTURE: begin
          spid_q[{ch_q, 4'b0000} +: 16] <= pid_if.pid_result;
          valid_q[ch_q]                 <= 1'b1;
          if (next_w[CH_W]) begin
            ch_q      <= next_ch;
            pid_set_q <= set_snap_q[{next_ch, 4'b0000} +: 16];
            pid_cur_q <= cur_snap_q[{next_ch, 4'b0000} +: 16];
            state_q   <= S_LOAD;
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign pid_if.pid_ch         = ch_q;
  assign pid_if.pid_speed_set  = pid_set_q;
  assign pid_if.pid_curr_speed = pid_cur_q;
  assign pid_if.ctrl_en        = ctrl_en_q;

  assign oSpeedPID  = spid_q;
  assign oValid     = valid_q;
  assign oBusy      = busy_q;
  assign oRoundDone = done_q;
  assign oOverrun   = ovr_q;

endmodule

// File: tb/tb_pid_channel_scheduler.sv
// Bench for pid_channel_scheduler: mock PID cores, event monitor, and a round-level reference model.
module tb_pid_channel_scheduler;

  localparam int NCH  = 4;
  localparam int PER  = 100;
  localparam int OPER = 20;
  localparam int LAT  = 4;
  localparam int SLOT = LAT + 3;

  typedef struct {
    int          c;
    int          ch;
    logic [15:0] s;
    logic [15:0] u;
  } strobe_t;

  typedef struct {
    int          c;
    logic [3:0]  v;
  } valid_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic        rst, en, en2, clr, clr2;
  logic [3:0]  mask;
  logic [63:0] sset, scur;
  logic [63:0] spid, spid2;
  logic [3:0]  valid, valid2;
  logic        busy, busy2, done, done2, ovr, ovr2;

  logic [15:0] set_v [NCH];
  logic [15:0] cur_v [NCH];
  logic [15:0] snap_set [NCH];
  logic [15:0] snap_cur [NCH];
  logic [15:0] mdl_pid [NCH];
  logic [3:0]  snap_mask;

  strobe_t st_q [$];
  valid_t  vq [$];
  int      dq [$];
  int      ov_st_q [$];

  logic [15:0] m_pend, m2_pend;
  int          m_cnt = 0;
  int          m2_cnt = 0;

  pid_channel_scheduler_if #(.CH_W(2)) pif ();
  pid_channel_scheduler_if #(.CH_W(2)) pif2 ();

  pid_channel_scheduler #(.NUM_CH(NCH), .PERIOD_CYCLES(PER), .PID_LAT(LAT)) u_dut (
    .iClk100M(clk), .iRst(rst), .iEnable(en), .iChMask(mask),
    .iSpeedSet(sset), .iCurrSpeed(scur), .iClrOverrun(clr), .pid_if(pif),
    .oSpeedPID(spid), .oValid(valid), .oBusy(busy), .oRoundDone(done), .oOverrun(ovr)
  );

  pid_channel_scheduler #(.NUM_CH(NCH), .PERIOD_CYCLES(OPER), .PID_LAT(LAT)) u_ovr (
    .iClk100M(clk), .iRst(rst), .iEnable(en2), .iChMask(mask),
    .iSpeedSet(sset), .iCurrSpeed(scur), .iClrOverrun(clr2), .pid_if(pif2),
    .oSpeedPID(spid2), .oValid(valid2), .oBusy(busy2), .oRoundDone(done2), .oOverrun(ovr2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Mock cores: result is garbage until LAT cycles after the strobe, then set - curr + 16*ch.
  always @(posedge clk) begin
    if (pif.ctrl_en) begin
      m_pend         <= pif.pid_speed_set - pif.pid_curr_speed + (16'(pif.pid_ch) << 4);
      m_cnt          <= LAT;
      pif.pid_result <= 16'hDEAD;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) pif.pid_result <= m_pend;
    end
  end

  always @(posedge clk) begin
    if (pif2.ctrl_en) begin
      m2_pend         <= pif2.pid_speed_set - pif2.pid_curr_speed + (16'(pif2.pid_ch) << 4);
      m2_cnt          <= LAT;
      pif2.pid_result <= 16'hDEAD;
    end else if (m2_cnt != 0) begin
      m2_cnt <= m2_cnt - 1;
      if (m2_cnt == 1) pif2.pid_result <= m2_pend;
    end
  end

  // Mid-cycle event log; cyc is the index of the current cycle.
  always @(negedge clk) begin
    if (pif.ctrl_en) st_q.push_back('{cyc, int'(pif.pid_ch), pif.pid_speed_set, pif.pid_curr_speed});
    if (valid != 4'b0000) vq.push_back('{cyc, valid});
    if (done) dq.push_back(cyc);
    if (pif2.ctrl_en) ov_st_q.push_back(cyc);
  end

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      sset[16*i +: 16] = set_v[i];
      scur[16*i +: 16] = cur_v[i];
    end
  endtask

  task automatic randomize_inputs();
    mask = 4'($urandom);
    for (int i = 0; i < NCH; i++) begin
      set_v[i] = 16'($urandom);
      cur_v[i] = 16'($urandom);
    end
    drive();
  endtask

  task automatic snap();
    snap_mask = mask;
    snap_set  = set_v;
    snap_cur  = cur_v;
  endtask

  function automatic logic [63:0] pack_mdl();
    logic [63:0] r;
    for (int i = 0; i < NCH; i++) r[16*i +: 16] = mdl_pid[i];
    return r;
  endfunction

  // Expected round from the snapshot: j-th enabled channel strobes at t+2+j*SLOT, validates LAT+2 later.
  task automatic finish_round(input int t, input string tag);
    int      n;
    int      j;
    strobe_t s;
    valid_t  v;
    int      d;
    n = $countones(snap_mask);
    wait_until(t + n * SLOT + 3);
    chk_i({tag, "/n_strobe"}, st_q.size(), n);
    chk_i({tag, "/n_valid"}, vq.size(), n);
    chk_i({tag, "/n_done"}, dq.size(), (n != 0) ? 1 : 0);
    j = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (snap_mask[ch]) begin
        mdl_pid[ch] = snap_set[ch] - snap_cur[ch] + 16'(16 * ch);
        if (st_q.size() > 0) begin
          s = st_q.pop_front();
          chk_i({tag, "/strobe_cyc"}, s.c, t + 2 + j * SLOT);
          chk_i({tag, "/strobe_ch"}, s.ch, ch);
          chk_i({tag, "/strobe_set"}, int'(s.s), int'(snap_set[ch]));
          chk_i({tag, "/strobe_cur"}, int'(s.u), int'(snap_cur[ch]));
        end
        if (vq.size() > 0) begin
          v = vq.pop_front();
          chk_i({tag, "/valid_cyc"}, v.c, t + LAT + 4 + j * SLOT);
          chk_i({tag, "/valid_bits"}, int'(v.v), 1 << ch);
        end
        j++;
      end
    end
    if (n != 0 && dq.size() > 0) begin
      d = dq.pop_front();
      chk_i({tag, "/done_cyc"}, d, t + 1 + n * SLOT);
    end
    chk_v({tag, "/speed_pid"}, spid, pack_mdl());
    st_q.delete();
    vq.delete();
    dq.delete();
  endtask

  initial begin
    int t;
    int t2;
    rst = 1'b1; en = 1'b1; en2 = 1'b0; clr = 1'b0; clr2 = 1'b0;
    mask = 4'h0;
    for (int i = 0; i < NCH; i++) begin
      set_v[i] = '0; cur_v[i] = '0; mdl_pid[i] = '0;
    end
    drive();
    wait_until(3);

    chk_v("rst/speed_pid", spid, 64'h0);
    chk_i("rst/valid", int'(valid), 0);
    chk_i("rst/busy_done_ovr", int'({busy, done, ovr}), 0);
    chk_i("rst/ctrl_en", int'(pif.ctrl_en), 0);
    chk_i("rst/pid_ch", int'(pif.pid_ch), 0);

    // Full round; channel 3 speed changes during channel 0's WAIT and must not be seen.
    for (int i = 0; i < NCH; i++) set_v[i] = 16'd1000;
    cur_v[0] = 16'd500; cur_v[1] = 16'd2000; cur_v[2] = 16'd1000; cur_v[3] = 16'd0;
    mask = 4'hF;
    drive();
    rst = 1'b0;
    t = cyc + PER - 1;
    snap();
    wait_until(t + 4);
    chk_i("full/busy_mid", int'(busy), 1);
    cur_v[3] = 16'd2000;
    drive();
    finish_round(t, "full");
    chk_v("full/literal", spid, {16'd1048, 16'd32, 16'hFC28, 16'd500});
    chk_i("full/busy_after", int'(busy), 0);

    t += PER;
    snap();
    finish_round(t, "next_period");
    chk_i("next_period/ch3", int'(spid[63:48]), int'(16'hFC48));

    mask = 4'b1010;
    for (int i = 0; i < NCH; i++) begin
      set_v[i] = 16'($urandom);
      cur_v[i] = 16'($urandom);
    end
    drive();
    t += PER;
    snap();
    finish_round(t, "sparse");

    mask = 4'h0;
    t += PER;
    snap();
    finish_round(t, "zero_mask");
    chk_i("zero_mask/busy", int'(busy), 0);

    for (int k = 0; k < 6; k++) begin
      randomize_inputs();
      t += PER;
      snap();
      finish_round(t, "random");
    end

    // Disable mid-round: the round completes, then silence until re-enabled.
    randomize_inputs();
    mask = 4'hF;
    t += PER;
    snap();
    wait_until(t + 10);
    en = 1'b0;
    finish_round(t, "disable");
    wait_until(t + 250);
    chk_i("disable/quiet", st_q.size(), 0);
    en = 1'b1;
    t = cyc + PER - 1;
    snap();
    finish_round(t, "reenable");

    // Reset during channel 2's WAIT.
    randomize_inputs();
    mask = 4'hF;
    t += PER;
    snap();
    wait_until(t + 18);
    rst = 1'b1;
    wait_until(t + 19);
    chk_v("reset/speed_pid", spid, 64'h0);
    chk_i("reset/outs", int'({valid, busy, done, ovr, pif.ctrl_en, pif.pid_ch}), 0);
    chk_i("reset/pid_set", int'(pif.pid_speed_set), 0);
    chk_i("reset/pid_cur", int'(pif.pid_curr_speed), 0);
    st_q.delete(); vq.delete(); dq.delete();
    for (int i = 0; i < NCH; i++) mdl_pid[i] = '0;
    wait_until(t + 21);
    rst = 1'b0;
    t = cyc + PER - 1;
    snap();
    wait_until(t - 1);
    chk_i("reset/no_leftovers", st_q.size() + vq.size() + dq.size(), 0);
    finish_round(t, "post_reset");
    chk_i("main/no_overrun", int'(ovr), 0);

    // Short-period instance: every other tick lands mid-round.
    ov_st_q.delete();
    en2 = 1'b1;
    t2 = cyc + OPER - 1;
    wait_until(t2 + OPER);
    chk_i("ovr/before", int'(ovr2), 0);
    wait_until(t2 + OPER + 1);
    chk_i("ovr/set", int'(ovr2), 1);
    wait_until(t2 + 45);
    chk_i("ovr/sticky", int'(ovr2), 1);
    chk_i("ovr/n_strobe", ov_st_q.size(), 5);
    if (ov_st_q.size() >= 5) chk_i("ovr/round2_start", ov_st_q[4], t2 + 42);
    wait_until(t2 + 50);
    clr2 = 1'b1;
    wait_until(t2 + 51);
    clr2 = 1'b0;
    chk_i("ovr/cleared", int'(ovr2), 0);
    wait_until(t2 + 60);
    clr2 = 1'b1;
    wait_until(t2 + 61);
    clr2 = 1'b0;
    chk_i("ovr/clear_priority", int'(ovr2), 0);
    wait_until(t2 + 101);
    chk_i("ovr/set_again", int'(ovr2), 1);
    chk_i("ovr/n_strobe2", ov_st_q.size(), 11);
    if (ov_st_q.size() >= 9) chk_i("ovr/round3_start", ov_st_q[8], t2 + 82);
    en2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
